// File: rtl/ram_word_ctrl.sv
// Byte-wide single-port RAM with a multi-byte little-endian request front end.
// A request moves 0..BYTES bytes one per enabled cycle and then pulses resp_valid_out once.
module ram_word_ctrl #(
   parameter  int ADDR_WIDTH = 17,
   parameter  int BYTES      = 4,
   localparam int LW         = $clog2(BYTES) + 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  en_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic                  req_wr_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in,
   input  logic [LW-1:0]         req_len_in,
   input  logic [8*BYTES-1:0]    req_wdata_in,
   output logic                  resp_valid_out,
   output logic [8*BYTES-1:0]    resp_rdata_out
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LW-1:0]         len_q, len_d;
   logic [LW-1:0]         cnt_q, cnt_d;
   logic [LW-1:0]         ridx_q, ridx_d;
   logic                  rvalid_q, rvalid_d;
   logic [8*BYTES-1:0]    wdata_q, wdata_d;
   logic [8*BYTES-1:0]    cap_q, cap_d;
   logic [8*BYTES-1:0]    rdata_q, rdata_d;
   logic                  resp_valid_q, resp_valid_d;

   logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];
   logic [7:0]            mem_rdata_q;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [LW-1:0]         n_eff;
   logic                  last_byte;

   assign n_eff     = (req_len_in > LW'(BYTES)) ? LW'(BYTES) : req_len_in;
   assign mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
   assign last_byte = ((cnt_q + LW'(1)) == len_q);
   assign mem_we    = en_in && (state_q == WRITE);

   assign req_ready_out  = (state_q == IDLE);
   // A completion registered just before en_in fell stays pending until re-enabled.
   assign resp_valid_out = resp_valid_q & en_in;
   assign resp_rdata_out = rdata_q;

   // Storage has no reset; read port also freezes while disabled so in-flight data survives.
   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         mem[mem_addr] <= wdata_q[7:0];
      end
      if (en_in) begin
         mem_rdata_q <= mem[mem_addr];
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      ridx_d       = ridx_q;
      rvalid_d     = rvalid_q;
      wdata_d      = wdata_q;
      cap_d        = cap_q;
      rdata_d      = rdata_q;
      resp_valid_d = resp_valid_q;

      if (en_in) begin
         resp_valid_d = 1'b0;
         rvalid_d     = 1'b0;

         // Read data for the address issued last cycle lands in its byte lane now.
         for (int i = 0; i < BYTES; i++) begin
            if (rvalid_q && (ridx_q == LW'(i))) begin
               cap_d[8*i +: 8] = mem_rdata_q;
            end
         end

         case (state_q)
            IDLE: begin
               if (req_valid_in) begin
                  addr_d  = req_addr_in;
                  len_d   = n_eff;
                  cnt_d   = '0;
                  wdata_d = req_wdata_in;
                  cap_d   = '0;
                  if (n_eff == '0) begin
                     resp_valid_d = 1'b1;
                     if (!req_wr_in) begin
                        rdata_d = '0;
                     end
                  end else begin
                     state_d = req_wr_in ? WRITE : READ;
                  end
               end
            end
            WRITE: begin
               wdata_d = wdata_q >> 8;
               cnt_d   = cnt_q + LW'(1);
               if (last_byte) begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b1;
               end
            end
            READ: begin
               rvalid_d = 1'b1;
               ridx_d   = cnt_q;
               cnt_d    = cnt_q + LW'(1);
               if (last_byte) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               rdata_d      = cap_d;
               resp_valid_d = 1'b1;
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         ridx_q       <= '0;
         rvalid_q     <= 1'b0;
         wdata_q      <= '0;
         cap_q        <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         ridx_q       <= ridx_d;
         rvalid_q     <= rvalid_d;
         wdata_q      <= wdata_d;
         cap_q        <= cap_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
      end
   end

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Randomized bench for ram_word_ctrl against a byte-addressed reference memory
// with latency, data, wrap, enable-stall, reset-abort and back-to-back scenarios.
module tb_ram_word_ctrl;

   localparam int AW = 17;
   localparam int B  = 4;
   localparam int LW = 3;

   typedef struct {
      bit          wr;
      logic [AW-1:0] addr;
      int          len;
      logic [31:0] data;
   } txn_t;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          en_in = 1'b1;
   logic          req_valid_in = 1'b0;
   logic          req_ready_out;
   logic          req_wr_in = 1'b0;
   logic [AW-1:0] req_addr_in = '0;
   logic [LW-1:0] req_len_in = '0;
   logic [31:0]   req_wdata_in = '0;
   logic          resp_valid_out;
   logic [31:0]   resp_rdata_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;
   logic [7:0] mdl [int];

   always #5 clk_in = ~clk_in;

   ram_word_ctrl dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .en_in          (en_in),
      .req_valid_in   (req_valid_in),
      .req_ready_out  (req_ready_out),
      .req_wr_in      (req_wr_in),
      .req_addr_in    (req_addr_in),
      .req_len_in     (req_len_in),
      .req_wdata_in   (req_wdata_in),
      .resp_valid_out (resp_valid_out),
      .resp_rdata_out (resp_rdata_out)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic txn_t mk(input bit wr, input int addr, input int len, input logic [31:0] data);
      txn_t t;
      t.wr   = wr;
      t.addr = AW'(addr);
      t.len  = len;
      t.data = data;
      return t;
   endfunction

   function automatic int eff_len(input int len);
      return (len > B) ? B : len;
   endfunction

   function automatic int addr_of(input logic [AW-1:0] a, input int k);
      return (int'(a) + k) % (1 << AW);
   endfunction

   task automatic present(input txn_t t);
      req_wr_in    = t.wr;
      req_addr_in  = t.addr;
      req_len_in   = LW'(t.len);
      req_wdata_in = t.data;
      req_valid_in = 1'b1;
   endtask

   // Call at a point after a negedge with the request already presented and the block idle.
   task automatic finish_req(input txn_t t, input int stall_at, input bit has_next, input txn_t nx);
      int n, base, exp_lat, lat;
      bit got;
      logic [31:0] exp_d, mask;
      n       = eff_len(t.len);
      base    = (n == 0) ? 1 : (t.wr ? n + 1 : n + 2);
      exp_lat = base + ((stall_at > 0) ? 3 : 0);
      lat     = 0;
      got     = 1'b0;
      while (!got && lat < 64) begin
         @(negedge clk_in);
         lat++;
         if (lat == 1) begin
            if (has_next) present(nx);
            else req_valid_in = 1'b0;
         end
         en_in = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 3);
         #1;
         if (resp_valid_out) got = 1'b1;
      end
      n_txn++;
      $display("txn %0d wr=%0d addr=%05h len=%0d stall=%0d latency=%0d rdata=%08h",
               n_txn, t.wr, t.addr, t.len, stall_at, lat, resp_rdata_out);
      if (!got) begin
         check_val("resp_timeout", 64'(got), 64'd1);
         return;
      end
      check_val("latency", 64'(lat), 64'(exp_lat));
      if (!t.wr) begin
         exp_d = '0;
         mask  = '1;
         for (int k = 0; k < n; k++) begin
            if (mdl.exists(addr_of(t.addr, k))) exp_d[8*k +: 8] = mdl[addr_of(t.addr, k)];
            else mask[8*k +: 8] = 8'h00;
         end
         check_val("rdata", 64'(resp_rdata_out & mask), 64'(exp_d));
      end else begin
         for (int k = 0; k < n; k++) mdl[addr_of(t.addr, k)] = t.data[8*k +: 8];
      end
      if (has_next) begin
         check_val("b2b_ready", 64'(req_ready_out), 64'd1);
      end else begin
         @(negedge clk_in);
         #1;
         check_val("single_pulse", 64'(resp_valid_out), 64'd0);
      end
   endtask

   task automatic do_req(input txn_t t, input int stall_at);
      txn_t none;
      none = mk(0, 0, 0, 0);
      check_val("ready_idle", 64'(req_ready_out), 64'd1);
      present(t);
      finish_req(t, stall_at, 1'b0, none);
   endtask

   initial begin
      txn_t t0, t1, t2, none;
      none = mk(0, 0, 0, 0);

      // Power-on reset
      rst_n_in = 1'b0;
      #1;
      check_val("rst_ready", 64'(req_ready_out), 64'd1);
      check_val("rst_valid", 64'(resp_valid_out), 64'd0);
      check_val("rst_rdata", 64'(resp_rdata_out), 64'd0);
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      #1;

      // Basic write / readback
      do_req(mk(1, 'h10, 4, 32'hDDCCBBAA), 0);
      do_req(mk(0, 'h10, 4, 0), 0);
      check_val("rd_ddccbbaa", 64'(resp_rdata_out), 64'hDDCCBBAA);
      do_req(mk(0, 'h10, 1, 0), 0);
      check_val("byte_10", 64'(resp_rdata_out), 64'hAA);

      // Address wrap at the top of memory
      do_req(mk(1, 'h1FFFF, 2, 32'h2211), 0);
      do_req(mk(0, 'h1FFFF, 2, 0), 0);
      check_val("wrap_rd", 64'(resp_rdata_out), 64'h2211);
      do_req(mk(0, 'h0, 1, 0), 0);
      check_val("wrap_byte0", 64'(resp_rdata_out), 64'h22);

      // Single byte and zero-length read
      do_req(mk(1, 'h100, 1, 32'h5A), 0);
      do_req(mk(0, 'h100, 1, 0), 0);
      check_val("len1_rd", 64'(resp_rdata_out), 64'h5A);
      do_req(mk(0, 'h100, 0, 0), 0);
      check_val("len0_rd", 64'(resp_rdata_out), 64'h0);

      // Enable stall in the middle of a read
      do_req(mk(0, 'h10, 4, 0), 3);
      check_val("stall_rd", 64'(resp_rdata_out), 64'hDDCCBBAA);

      // Length above BYTES is clamped
      do_req(mk(1, 'h200, 7, 32'h87654321), 0);
      do_req(mk(0, 'h200, 6, 0), 0);
      check_val("clamp_rd", 64'(resp_rdata_out), 64'h87654321);

      // Reset two bytes into a 4-byte write
      do_req(mk(1, 'h300, 4, 32'h88776655), 0);
      present(mk(1, 'h300, 4, 32'h44332211));
      @(negedge clk_in);
      req_valid_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      check_val("abort_ready", 64'(req_ready_out), 64'd1);
      check_val("abort_valid", 64'(resp_valid_out), 64'd0);
      check_val("abort_rdata", 64'(resp_rdata_out), 64'd0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (3) begin
         @(negedge clk_in);
         #1;
         check_val("abort_no_resp", 64'(resp_valid_out), 64'd0);
      end
      mdl[int'('h300)] = 8'h11;
      mdl[int'('h301)] = 8'h22;
      do_req(mk(0, 'h300, 4, 0), 0);
      check_val("abort_rd", 64'(resp_rdata_out), 64'h88772211);

      // Back-to-back: write, read, zero-length read with valid held high
      t0 = mk(1, 'h400, 3, 32'h00C3B2A1);
      t1 = mk(0, 'h400, 3, 0);
      t2 = mk(0, 'h400, 0, 0);
      check_val("ready_idle", 64'(req_ready_out), 64'd1);
      present(t0);
      finish_req(t0, 0, 1'b1, t1);
      finish_req(t1, 0, 1'b1, t2);
      check_val("b2b_rd", 64'(resp_rdata_out), 64'h00C3B2A1);
      finish_req(t2, 0, 1'b0, none);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         txn_t t;
         int n, base, st;
         t.wr   = $urandom_range(0, 1);
         t.addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                               : AW'(32'h1FFF0 + $urandom_range(0, 15));
         t.len  = $urandom_range(0, 7);
         t.data = $urandom;
         n      = eff_len(t.len);
         base   = (n == 0) ? 1 : (t.wr ? n + 1 : n + 2);
         st     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, base) : 0;
         do_req(t, st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
